// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider, column/row counters and sync decode.
// Syncs and video_on are registered from the next coordinates so they always match px_x/px_y.
module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 2,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1'b1);
  localparam logic [DW-1:0] DIV_ZERO = DW'(1'b0);

  localparam logic [CW-1:0] C_ZERO   = CW'(1'b0);
  localparam logic [CW-1:0] C_ONE    = CW'(1'b1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISP);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISP);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISP + V_FP + V_SYNC - 1);

  localparam logic HS_ACT = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ACT = (VS_POL != 0) ? 1'b1 : 1'b0;

  // Refuse to elaborate when the coordinate width cannot hold the last column/row.
  if ((H_TOTAL > (2 ** CW)) || (V_TOTAL > (2 ** CW))) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  function automatic logic in_window(input logic [CW-1:0] v,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    in_window = (v >= lo) && (v <= hi);
  endfunction

  logic [DW-1:0] div_cnt_r;
  logic [CW-1:0] px_x_r;
  logic [CW-1:0] px_y_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          video_on_r;

  logic          pix_en_s;
  logic [DW-1:0] div_next_s;
  logic [CW-1:0] x_next_s;
  logic [CW-1:0] y_next_s;

  // Divider tick and next-state computation for the divider and both counters.
  always_comb begin
    pix_en_s   = en && (div_cnt_r == DIV_LAST);
    div_next_s = div_cnt_r;
    x_next_s   = px_x_r;
    y_next_s   = px_y_r;
    if (!en) begin
      div_next_s = div_cnt_r;
    end else if (div_cnt_r == DIV_LAST) begin
      div_next_s = DIV_ZERO;
    end else begin
      div_next_s = div_cnt_r + DIV_ONE;
    end
    if (pix_en_s) begin
      if (px_x_r == H_LAST) begin
        x_next_s = C_ZERO;
        if (px_y_r == V_LAST) begin
          y_next_s = C_ZERO;
        end else begin
          y_next_s = px_y_r + C_ONE;
        end
      end else begin
        x_next_s = px_x_r + C_ONE;
        y_next_s = px_y_r;
      end
    end else begin
      x_next_s = px_x_r;
      y_next_s = px_y_r;
    end
  end

  // Timing state; decode uses next coordinates so there is no one-pixel sync skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r  <= DIV_ZERO;
      px_x_r     <= C_ZERO;
      px_y_r     <= C_ZERO;
      hsync_r    <= ~HS_ACT;
      vsync_r    <= ~VS_ACT;
      video_on_r <= 1'b1;
    end else begin
      div_cnt_r  <= div_next_s;
      px_x_r     <= x_next_s;
      px_y_r     <= y_next_s;
      hsync_r    <= in_window(x_next_s, HS_FIRST, HS_LAST) ? HS_ACT : ~HS_ACT;
      vsync_r    <= in_window(y_next_s, VS_FIRST, VS_LAST) ? VS_ACT : ~VS_ACT;
      video_on_r <= (x_next_s < H_VIS) && (y_next_s < V_VIS);
    end
  end

  assign pix_en      = pix_en_s;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign video_on    = video_on_r;
  assign px_x        = px_x_r;
  assign px_y        = px_y_r;
  assign line_start  = pix_en_s && (px_x_r == C_ZERO);
  assign frame_start = pix_en_s && (px_x_r == C_ZERO) && (px_y_r == C_ZERO);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (A), default H with a 10-line frame (B), tiny CLK_DIV=1 timing (C).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic pe_a, hs_a, vs_a, vo_a, ls_a, fs_a;
  logic pe_b, hs_b, vs_b, vo_b, ls_b, fs_b;
  logic pe_c, hs_c, vs_c, vo_c, ls_c, fs_c;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [3:0] x_c, y_c;

  int vec = 0;
  int miss = 0;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vo_a), .px_x(x_a), .px_y(y_a), .line_start(ls_a), .frame_start(fs_a));

  vga_timing_gen #(.V_DISP(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(vo_b), .px_x(x_b), .px_y(y_b), .line_start(ls_b), .frame_start(fs_b));

  vga_timing_gen #(.H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_DISP(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .HS_POL(1), .VS_POL(1), .CW(4)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .pix_en(pe_c), .hsync(hs_c), .vsync(vs_c),
    .video_on(vo_c), .px_x(x_c), .px_y(y_c), .line_start(ls_c), .frame_start(fs_c));

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (x_a !== 10'd0 || y_a !== 10'd0) begin miss++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", x_a, y_a); end
    vec++; if (hs_a !== 1'b1 || vs_a !== 1'b1) begin miss++; $display("FAIL reset_sync: got hs=%b vs=%b expected 1,1", hs_a, vs_a); end
    vec++; if (vo_a !== 1'b1) begin miss++; $display("FAIL reset_video_on: got %b expected 1", vo_a); end
    vec++; if (pe_a !== 1'b0) begin miss++; $display("FAIL reset_pix_en: got %b expected 0", pe_a); end
    vec++; if (hs_c !== 1'b0 || vs_c !== 1'b0) begin miss++; $display("FAIL reset_sync_pol1: got hs=%b vs=%b expected 0,0", hs_c, vs_c); end
    en_a = 1'b1;
    #1;
    vec++; if (pe_a !== 1'b0 || fs_a !== 1'b0) begin miss++; $display("FAIL reset_en_pix_en: got pe=%b fs=%b expected 0,0", pe_a, fs_a); end
    @(negedge clk);
    vec++; if (x_a !== 10'd0 || pe_a !== 1'b0) begin miss++; $display("FAIL reset_hold: got x=%0d pe=%b expected 0,0", x_a, pe_a); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
  endtask

  // A runs from reset release: after c clocks, px_x = (c/2) mod 800, pix_en on odd c.
  task automatic test_line();
    int x, y;
    logic exp_hs, exp_vo, exp_pe, exp_ls;
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      x = (c / 2) % 800;
      y = (c / 2) / 800;
      exp_pe = (c % 2) == 1;
      exp_hs = !(x >= 656 && x <= 751);
      exp_vo = (x < 640);
      exp_ls = exp_pe && (x == 0);
      vec++; if (x_a !== 10'(x) || y_a !== 10'(y)) begin miss++; $display("FAIL line_xy c=%0d: got %0d,%0d expected %0d,%0d", c, x_a, y_a, x, y); end
      vec++; if (pe_a !== exp_pe) begin miss++; $display("FAIL line_pix_en c=%0d: got %b expected %b", c, pe_a, exp_pe); end
      vec++; if (hs_a !== exp_hs) begin miss++; $display("FAIL line_hsync x=%0d: got %b expected %b", x, hs_a, exp_hs); end
      vec++; if (vo_a !== exp_vo) begin miss++; $display("FAIL line_video_on x=%0d: got %b expected %b", x, vo_a, exp_vo); end
      vec++; if (ls_a !== exp_ls || vs_a !== 1'b1) begin miss++; $display("FAIL line_ls_vs c=%0d: got ls=%b vs=%b expected %b,1", c, ls_a, vs_a, exp_ls); end
    end
  endtask

  task automatic test_en_pause();
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (x_a == 10'd100 && pe_a == 1'b1) begin found = 1'b1; break; end
    end
    vec++; if (!found) begin miss++; $display("FAIL pause_reach: got found=0 expected found=1"); end
    en_a = 1'b0;
    #1;
    vec++; if (pe_a !== 1'b0) begin miss++; $display("FAIL pause_pix_en: got %b expected 0", pe_a); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vec++; if (x_a !== 10'd100 || y_a !== 10'd1) begin miss++; $display("FAIL pause_xy: got %0d,%0d expected 100,1", x_a, y_a); end
      vec++; if (hs_a !== 1'b1 || vs_a !== 1'b1 || vo_a !== 1'b1 || pe_a !== 1'b0 || ls_a !== 1'b0) begin
        miss++; $display("FAIL pause_outputs: got hs=%b vs=%b vo=%b pe=%b ls=%b expected 1,1,1,0,0", hs_a, vs_a, vo_a, pe_a, ls_a);
      end
    end
    en_a = 1'b1;
    #1;
    vec++; if (pe_a !== 1'b1) begin miss++; $display("FAIL resume_phase: got pix_en=%b expected 1", pe_a); end
    @(negedge clk);
    vec++; if (x_a !== 10'd101 || pe_a !== 1'b0) begin miss++; $display("FAIL resume_next: got x=%0d pe=%b expected 101,0", x_a, pe_a); end
    @(negedge clk);
    vec++; if (x_a !== 10'd101 || pe_a !== 1'b1) begin miss++; $display("FAIL resume_hold: got x=%0d pe=%b expected 101,1", x_a, pe_a); end
    en_a = 1'b0;
  endtask

  // C: H_TOTAL=8, V_TOTAL=6, one pixel per clock, active-high syncs.
  task automatic test_small();
    int x, y, last_fs;
    logic exp_hs, exp_vs, exp_vo, exp_fs;
    en_c = 1'b1;
    #1;
    vec++; if (pe_c !== 1'b1 || fs_c !== 1'b1) begin miss++; $display("FAIL small_start: got pe=%b fs=%b expected 1,1", pe_c, fs_c); end
    last_fs = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      x = c % 8;
      y = (c / 8) % 6;
      exp_hs = (x >= 5 && x <= 6);
      exp_vs = (y == 4);
      exp_vo = (x < 4) && (y < 3);
      exp_fs = (x == 0) && (y == 0);
      vec++; if (x_c !== 4'(x) || y_c !== 4'(y)) begin miss++; $display("FAIL small_xy c=%0d: got %0d,%0d expected %0d,%0d", c, x_c, y_c, x, y); end
      vec++; if (hs_c !== exp_hs || vs_c !== exp_vs) begin miss++; $display("FAIL small_sync c=%0d: got hs=%b vs=%b expected %b,%b", c, hs_c, vs_c, exp_hs, exp_vs); end
      vec++; if (vo_c !== exp_vo || pe_c !== 1'b1) begin miss++; $display("FAIL small_vo_pe c=%0d: got vo=%b pe=%b expected %b,1", c, vo_c, pe_c, exp_vo); end
      vec++; if (fs_c !== exp_fs) begin miss++; $display("FAIL small_frame_start c=%0d: got %b expected %b", c, fs_c, exp_fs); end
      if (fs_c === 1'b1) begin
        vec++; if (c - last_fs != 48) begin miss++; $display("FAIL small_fs_period: got %0d expected 48", c - last_fs); end
        last_fs = c;
      end
    end
    en_c = 1'b0;
  endtask

  // B: 800x10 raster at CLK_DIV=2 -> 1600 clks per line, 16000 per frame, vsync rows 6..7.
  task automatic test_frame();
    int last_ls = -1, last_fs = -1, ls_cnt = 0, fs_cnt = 0, row;
    logic prev_ls = 1'b0;
    en_b = 1'b1;
    for (int c = 1; c <= 40000; c++) begin
      @(negedge clk);
      if (ls_b === 1'b1) begin
        row = ls_cnt % 10;
        vec++; if (prev_ls !== 1'b0) begin miss++; $display("FAIL frame_ls_width c=%0d: got 2+ clk pulse expected 1 clk", c); end
        vec++; if (y_b !== 10'(row) || x_b !== 10'd0) begin miss++; $display("FAIL frame_row c=%0d: got y=%0d x=%0d expected %0d,0", c, y_b, x_b, row); end
        vec++; if (vs_b !== !(row == 6 || row == 7)) begin miss++; $display("FAIL frame_vsync row=%0d: got %b expected %b", row, vs_b, !(row == 6 || row == 7)); end
        vec++; if (vo_b !== (row < 4)) begin miss++; $display("FAIL frame_video_on row=%0d: got %b expected %b", row, vo_b, (row < 4)); end
        if (last_ls >= 0) begin
          vec++; if (c - last_ls != 1600) begin miss++; $display("FAIL frame_ls_period: got %0d expected 1600", c - last_ls); end
        end
        last_ls = c;
        ls_cnt++;
      end
      if (fs_b === 1'b1) begin
        if (last_fs >= 0) begin
          vec++; if (c - last_fs != 16000) begin miss++; $display("FAIL frame_fs_period: got %0d expected 16000", c - last_fs); end
        end else begin
          vec++; if (c != 1) begin miss++; $display("FAIL frame_first_fs: got clk %0d expected 1", c); end
        end
        last_fs = c;
        fs_cnt++;
      end
      prev_ls = ls_b;
      if (fs_cnt == 3) break;
    end
    vec++; if (fs_cnt != 3 || ls_cnt != 21) begin miss++; $display("FAIL frame_counts: got fs=%0d ls=%0d expected 3,21", fs_cnt, ls_cnt); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 14000; i++) begin
      @(negedge clk);
      if (x_b == 10'd700 && y_b == 10'd6) begin found = 1'b1; break; end
    end
    vec++; if (!found) begin miss++; $display("FAIL mid_reach: got found=0 expected found=1"); end
    vec++; if (hs_b !== 1'b0 || vs_b !== 1'b0) begin miss++; $display("FAIL mid_sync_active: got hs=%b vs=%b expected 0,0", hs_b, vs_b); end
    rst_b = 1'b1;
    @(negedge clk);
    vec++; if (x_b !== 10'd0 || y_b !== 10'd0) begin miss++; $display("FAIL mid_reset_xy: got %0d,%0d expected 0,0", x_b, y_b); end
    vec++; if (hs_b !== 1'b1 || vs_b !== 1'b1 || vo_b !== 1'b1) begin miss++; $display("FAIL mid_reset_out: got hs=%b vs=%b vo=%b expected 1,1,1", hs_b, vs_b, vo_b); end
    vec++; if (fs_b !== 1'b0 || pe_b !== 1'b0) begin miss++; $display("FAIL mid_reset_pulse: got fs=%b pe=%b expected 0,0", fs_b, pe_b); end
    rst_b = 1'b0;
    @(negedge clk);
    vec++; if (fs_b !== 1'b1 || x_b !== 10'd0) begin miss++; $display("FAIL mid_first_fs: got fs=%b x=%0d expected 1,0", fs_b, x_b); end
    @(negedge clk);
    vec++; if (fs_b !== 1'b0 || x_b !== 10'd1) begin miss++; $display("FAIL mid_after_fs: got fs=%b x=%0d expected 0,1", fs_b, x_b); end
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line();
    test_en_pause();
    test_small();
    test_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
